// File: rtl/pkt_cutter_pkg.sv
// rtl/pkt_cutter_pkg.sv - shared types and helpers for the packet cutter
//
// Purpose: FSM state encoding, word geometry and the tstrb lane-mask helper
//          used by pkt_cutter.
// Ports:   none (package).
package pkt_cutter_pkg;

  localparam int BYTES_PER_WORD = 32;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    PASS  = 2'd1,
    DROP  = 2'd2
  } cut_state_e;

  // Low last_bytes lanes set; 32 or more yields a full word.
  function automatic logic [BYTES_PER_WORD-1:0] strb_mask(input logic [5:0] last_bytes);
    logic [BYTES_PER_WORD-1:0] m;
    if (last_bytes >= 6'd32) m = '1;
    else                     m = (32'h1 << last_bytes) - 32'h1;
    return m;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - single-stage stream register with ready handshake
//
// Purpose: registers one stream word; accepts a new word whenever the slot
//          is empty or is being drained in the same cycle.
// Ports:   clk, reset (async, active-high)
//          in_tdata/in_tstrb/in_tuser/in_tlast/in_tvalid -> in_tready
//          out_tdata/out_tstrb/out_tuser/out_tlast/out_tvalid <- out_tready
module axis_reg_slice #(
  parameter int DATA_W = 256,
  parameter int STRB_W = 32,
  parameter int USER_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [STRB_W-1:0] in_tstrb,
  input  logic [USER_W-1:0] in_tuser,
  input  logic              in_tlast,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic [STRB_W-1:0] out_tstrb,
  output logic [USER_W-1:0] out_tuser,
  output logic              out_tlast,
  output logic              out_tvalid,
  input  logic              out_tready
);

  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [STRB_W-1:0] tstrb_q, tstrb_d;
  logic [USER_W-1:0] tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic              valid_q, valid_d;

  always_comb begin
    in_tready = !valid_q || out_tready;
    tdata_d   = tdata_q;
    tstrb_d   = tstrb_q;
    tuser_d   = tuser_q;
    tlast_d   = tlast_q;
    valid_d   = valid_q;
    if (in_tvalid && in_tready) begin
      tdata_d = in_tdata;
      tstrb_d = in_tstrb;
      tuser_d = in_tuser;
      tlast_d = in_tlast;
      valid_d = 1'b1;
    end else if (out_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdata_q <= '0;
      tstrb_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      tdata_q <= tdata_d;
      tstrb_q <= tstrb_d;
      tuser_q <= tuser_d;
      tlast_q <= tlast_d;
      valid_q <= valid_d;
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tstrb  = tstrb_q;
  assign out_tuser  = tuser_q;
  assign out_tlast  = tlast_q;
  assign out_tvalid = valid_q;

endmodule

// File: rtl/pkt_cutter.sv
// rtl/pkt_cutter.sv - truncates stream packets to a programmed byte length
//
// Purpose: optionally cuts each packet to cut_bytes: forces tlast early,
//          masks tstrb on the cut word, drops the tail words and rewrites
//          the tuser length field on the first word.
// Ports:   clk, reset (async, active-high)
//          s_axis_* : input stream (tuser carries length at LEN_POS)
//          m_axis_* : truncated output stream, one register stage
//          cut_en, cut_bytes : sampled on the first word of each packet
//          rst_stats, cut_pkt_cnt : truncated-packet statistics
// Config:  PKT_CUTTER_STATS_EN builds the cut_pkt_cnt counter; otherwise
//          cut_pkt_cnt reads 0 and rst_stats is ignored.
module pkt_cutter
  import pkt_cutter_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int LEN_POS              = 0,
  parameter int CUT_WIDTH            = 16,
  parameter int C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              cut_en,
  input  logic [CUT_WIDTH-1:0]              cut_bytes,
  input  logic                              rst_stats,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     cut_pkt_cnt
);

  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int IDX_W  = CUT_WIDTH - 5;

  cut_state_e        state_q, state_d;
  logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
  logic              cut_active_q, cut_active_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic [5:0]        last_bytes_q, last_bytes_d;

  logic [15:0]          pkt_len, cut_len16;
  logic [CUT_WIDTH-1:0] cut_m1;
  logic [IDX_W-1:0]     last_idx_now, cur_idx;
  logic [5:0]           last_bytes_now;
  logic                 cut_now, slice_ready, accept, cut_hit;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  slice_tdata;
  logic [STRB_W-1:0]               slice_tstrb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] slice_tuser;
  logic                            slice_tlast, slice_tvalid;

  // Cut geometry from the live config; only used on a packet's first word.
  assign pkt_len        = s_axis_tuser[LEN_POS +: 16];
  assign cut_len16      = 16'(cut_bytes);
  assign cut_m1         = cut_bytes - 1'b1;
  assign last_idx_now   = cut_m1[CUT_WIDTH-1:5];
  assign last_bytes_now = {1'b0, cut_m1[4:0]} + 6'd1;
  assign cut_now        = cut_en && (cut_bytes != '0) && (pkt_len > cut_len16);

  // Index of the word being accepted in PASS; saturates for oversize packets.
  assign cur_idx = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;

  // DROP swallows words without touching the output slice.
  assign s_axis_tready = (state_q == DROP) || slice_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    cut_active_d = cut_active_q;
    last_idx_d   = last_idx_q;
    last_bytes_d = last_bytes_q;
    slice_tvalid = 1'b0;
    slice_tdata  = s_axis_tdata;
    slice_tstrb  = s_axis_tstrb;
    slice_tuser  = s_axis_tuser;
    slice_tlast  = s_axis_tlast;
    cut_hit      = 1'b0;
    case (state_q)
      FIRST: begin
        if (accept) begin
          cut_active_d = cut_now;
          last_idx_d   = last_idx_now;
          last_bytes_d = last_bytes_now;
          word_cnt_d   = '0;
          slice_tvalid = 1'b1;
          if (cut_now) slice_tuser[LEN_POS +: 16] = cut_len16;
          if (cut_now && last_idx_now == '0) begin
            slice_tlast = 1'b1;
            slice_tstrb = strb_mask(last_bytes_now);
            cut_hit     = 1'b1;
            state_d     = s_axis_tlast ? FIRST : DROP;
          end else begin
            state_d     = s_axis_tlast ? FIRST : PASS;
          end
        end
      end
      PASS: begin
        if (accept) begin
          word_cnt_d   = cur_idx;
          slice_tvalid = 1'b1;
          if (cut_active_q && cur_idx == last_idx_q) begin
            slice_tlast = 1'b1;
            slice_tstrb = s_axis_tstrb & strb_mask(last_bytes_q);
            cut_hit     = 1'b1;
            state_d     = s_axis_tlast ? FIRST : DROP;
          end else if (s_axis_tlast) begin
            state_d     = FIRST;
          end
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) state_d = FIRST;
      end
      default: state_d = FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FIRST;
      word_cnt_q   <= '0;
      cut_active_q <= 1'b0;
      last_idx_q   <= '0;
      last_bytes_q <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      cut_active_q <= cut_active_d;
      last_idx_q   <= last_idx_d;
      last_bytes_q <= last_bytes_d;
    end
  end

  axis_reg_slice #(
    .DATA_W (C_S_AXIS_DATA_WIDTH),
    .STRB_W (STRB_W),
    .USER_W (C_S_AXIS_TUSER_WIDTH)
  ) u_out_slice (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (slice_tdata),
    .in_tstrb   (slice_tstrb),
    .in_tuser   (slice_tuser),
    .in_tlast   (slice_tlast),
    .in_tvalid  (slice_tvalid),
    .in_tready  (slice_ready),
    .out_tdata  (m_axis_tdata),
    .out_tstrb  (m_axis_tstrb),
    .out_tuser  (m_axis_tuser),
    .out_tlast  (m_axis_tlast),
    .out_tvalid (m_axis_tvalid),
    .out_tready (m_axis_tready)
  );

`ifdef PKT_CUTTER_STATS_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] cnt_q, cnt_d;

  // A clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (rst_stats)    cnt_d = '0;
    else if (cut_hit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cut_pkt_cnt = cnt_q;
`else
  logic unused_stats;
  assign unused_stats = rst_stats ^ cut_hit;
  assign cut_pkt_cnt  = '0;
`endif

endmodule
